// File: rtl/pio_out_arbiter_if.sv
// Bundle of the two requester write ports and the four PIO export values.
// The arbiter connects through the slave modport. Requesters, or a bench
// standing in for them, connect through the master modport.
//
// Handshake: a requester raises rN_req with rN_sel/rN_data (and rN_lock when
// it wants to keep ownership after this beat) and holds them stable until
// the cycle in which rN_ack is 1. rN_ack is a single-cycle completion pulse,
// and by that cycle the target register already holds the new value. A
// requester may present its next beat in the cycle after the one in which
// it sees the ack.
interface pio_out_arbiter_if;
    logic        r0_req;
    logic [1:0]  r0_sel;
    logic [31:0] r0_data;
    logic        r0_lock;
    logic        r0_ack;

    logic        r1_req;
    logic [1:0]  r1_sel;
    logic [31:0] r1_data;
    logic        r1_lock;
    logic        r1_ack;

    logic [31:0] hexl_out;
    logic [31:0] hexr_out;
    logic [31:0] ledsred_out;
    logic [31:0] ledsgreen_out;
    logic [1:0]  owner;

    // Requester side: drives requests, observes acks and export values.
    modport master (
        output r0_req, r0_sel, r0_data, r0_lock,
        output r1_req, r1_sel, r1_data, r1_lock,
        input  r0_ack, r1_ack,
        input  hexl_out, hexr_out, ledsred_out, ledsgreen_out, owner
    );

    // Arbiter side.
    modport slave (
        input  r0_req, r0_sel, r0_data, r0_lock,
        input  r1_req, r1_sel, r1_data, r1_lock,
        output r0_ack, r1_ack,
        output hexl_out, hexr_out, ledsred_out, ledsgreen_out, owner
    );
endinterface

// File: rtl/pio_out_arbiter.sv
// Two-requester write arbiter in front of four 32-bit PIO export registers
// (two seven-segment hex banks, red LEDs and green LEDs).
//
// One requester owns the register file at a time. Each beat takes two
// cycles. In OWNn the beat is written, and in ACKn the ack is visible and
// lock is sampled. A locked owner keeps the bus for at most MAX_BURST beats
// and then has to re-arbitrate. Contention in IDLE is settled by a
// round-robin pointer that always points away from the requester whose
// tenure ended last.
module pio_out_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter logic [31:0] HEX_BLANK = 32'hFFFF_FFFF
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    pio_out_arbiter_if.slave bus,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OWN0 = 3'd1,
        S_ACK0 = 3'd2,
        S_OWN1 = 3'd3,
        S_ACK1 = 3'd4
    } state_t;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    localparam logic [1:0] LP_OWNER_NONE = 2'b00;
    localparam logic [1:0] LP_OWNER_R0   = 2'b01;
    localparam logic [1:0] LP_OWNER_R1   = 2'b10;

    // Arbitration state. r_rr = 0 favours r0 and r_rr = 1 favours r1.
    state_t      r_state;
    logic        r_rr;
    logic [3:0]  r_beat;
    logic        r_ack0;
    logic        r_ack1;
    logic [1:0]  r_owner;

    // Export registers.
    logic [31:0] r_hexl;
    logic [31:0] r_hexr;
    logic [31:0] r_ledsred;
    logic [31:0] r_ledsgreen;

    // Write port, taken only from the current owner's inputs.
    logic        w_wr_en;
    logic [1:0]  w_wr_sel;
    logic [31:0] w_wr_data;
    logic        w_burst_left;

    // The beat counter only advances from OWN, and OWN is only re-entered
    // while the counter is below MAX_BURST. That keeps it bounded within a
    // tenure, so it never wraps.
    assign w_burst_left = (r_beat < LP_MAX_BURST);

    // Select the owner's write beat. The non-owner's inputs are never looked at.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_sel  = 2'd0;
        w_wr_data = 32'd0;
        case (r_state)
            S_OWN0: begin
                w_wr_en   = bus.r0_req;
                w_wr_sel  = bus.r0_sel;
                w_wr_data = bus.r0_data;
            end
            S_OWN1: begin
                w_wr_en   = bus.r1_req;
                w_wr_sel  = bus.r1_sel;
                w_wr_data = bus.r1_data;
            end
            default: begin
                w_wr_en   = 1'b0;
                w_wr_sel  = 2'd0;
                w_wr_data = 32'd0;
            end
        endcase
    end

    // Arbitration FSM with registered ack and owner outputs.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_beat  <= 4'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_owner <= LP_OWNER_NONE;
        end else begin
            // Acks are single-cycle pulses. Only the OWN->ACK step raises one.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_beat <= 4'd0;
                    if (bus.r0_req && (!bus.r1_req || !r_rr)) begin
                        r_state <= S_OWN0;
                        r_owner <= LP_OWNER_R0;
                    end else if (bus.r1_req) begin
                        r_state <= S_OWN1;
                        r_owner <= LP_OWNER_R1;
                    end else begin
                        r_state <= S_IDLE;
                        r_owner <= LP_OWNER_NONE;
                    end
                end
                S_OWN0: begin
                    if (bus.r0_req) begin
                        r_state <= S_ACK0;
                        r_ack0  <= 1'b1;
                        r_beat  <= r_beat + 4'd1;
                    end else begin
                        // The owner withdrew: give up the tenure without writing.
                        r_state <= S_IDLE;
                        r_rr    <= 1'b1;
                        r_owner <= LP_OWNER_NONE;
                    end
                end
                S_ACK0: begin
                    if (bus.r0_lock && w_burst_left) begin
                        r_state <= S_OWN0;
                    end else begin
                        r_state <= S_IDLE;
                        r_rr    <= 1'b1;
                        r_owner <= LP_OWNER_NONE;
                    end
                end
                S_OWN1: begin
                    if (bus.r1_req) begin
                        r_state <= S_ACK1;
                        r_ack1  <= 1'b1;
                        r_beat  <= r_beat + 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_rr    <= 1'b0;
                        r_owner <= LP_OWNER_NONE;
                    end
                end
                S_ACK1: begin
                    if (bus.r1_lock && w_burst_left) begin
                        r_state <= S_OWN1;
                    end else begin
                        r_state <= S_IDLE;
                        r_rr    <= 1'b0;
                        r_owner <= LP_OWNER_NONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_owner <= LP_OWNER_NONE;
                end
            endcase
        end
    end

    // Export registers. Reset wins over a pending write, so a reset that
    // lands on an OWN cycle aborts that beat.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_hexl      <= HEX_BLANK;
            r_hexr      <= HEX_BLANK;
            r_ledsred   <= 32'd0;
            r_ledsgreen <= 32'd0;
        end else if (w_wr_en) begin
            case (w_wr_sel)
                2'd0:    r_hexl      <= w_wr_data;
                2'd1:    r_hexr      <= w_wr_data;
                2'd2:    r_ledsred   <= w_wr_data;
                default: r_ledsgreen <= w_wr_data;
            endcase
        end
    end

    assign bus.r0_ack        = r_ack0;
    assign bus.r1_ack        = r_ack1;
    assign bus.owner         = r_owner;
    assign bus.hexl_out      = r_hexl;
    assign bus.hexr_out      = r_hexr;
    assign bus.ledsred_out   = r_ledsred;
    assign bus.ledsgreen_out = r_ledsgreen;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_pio_out_arbiter.sv
// Bench for pio_out_arbiter: directed scenarios followed by a random phase.
// Every cycle the outputs are compared against a reference model. The model
// tracks the owner, the ack phase and the expected export contents from the
// driven inputs alone. Each requester is a queue of pending beats that
// retires a beat when it sees its ack.
module tb_pio_out_arbiter;

    localparam int          MAX_BURST = 4;
    localparam logic [31:0] HEX_BLANK = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk_clk = ~clk_clk;

    pio_out_arbiter_if bus ();

    pio_out_arbiter #(
        .MAX_BURST (MAX_BURST),
        .HEX_BLANK (HEX_BLANK)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- bench state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    beat_t       q0[$];
    beat_t       q1[$];
    logic        burst0 = 1'b0;
    logic        burst1 = 1'b0;
    logic        mask0  = 1'b0;
    int          ack_log[$];
    logic [0:0]  exp_q[$];
    int          ack_cnt0 = 0;
    int          ack_cnt1 = 0;

    // Reference model: owner 0 = none, 1 = r0, 2 = r1. m_last is the
    // requester whose tenure ended last, so the other one wins a tie.
    int          m_owner;
    logic        m_ack;
    int          m_last;
    int          m_cnt;
    logic [31:0] exp_regs [4];

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner     = 0;
        m_ack       = 1'b0;
        m_last      = 1;
        m_cnt       = 0;
        exp_regs[0] = HEX_BLANK;
        exp_regs[1] = HEX_BLANK;
        exp_regs[2] = 32'd0;
        exp_regs[3] = 32'd0;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        bus.r0_req  = (q0.size() > 0) && !mask0;
        bus.r0_sel  = (q0.size() > 0) ? q0[0].sel  : 2'd0;
        bus.r0_data = (q0.size() > 0) ? q0[0].data : 32'd0;
        bus.r0_lock = burst0 && (q0.size() > 0);
        bus.r1_req  = (q1.size() > 0);
        bus.r1_sel  = (q1.size() > 0) ? q1[0].sel  : 2'd0;
        bus.r1_data = (q1.size() > 0) ? q1[0].data : 32'd0;
        bus.r1_lock = burst1 && (q1.size() > 0);
    endtask

    // Advance one clock, check everything against the model, then update
    // the requesters from the observed acks.
    task automatic step();
        logic        p_req  [2];
        logic        p_lock [2];
        logic [1:0]  p_sel  [2];
        logic [31:0] p_data [2];
        logic        p_rst_n;
        int          n;
        p_req[0]  = bus.r0_req;   p_req[1]  = bus.r1_req;
        p_lock[0] = bus.r0_lock;  p_lock[1] = bus.r1_lock;
        p_sel[0]  = bus.r0_sel;   p_sel[1]  = bus.r1_sel;
        p_data[0] = bus.r0_data;  p_data[1] = bus.r1_data;
        p_rst_n   = reset_reset_n;
        @(posedge clk_clk);
        #1;
        if (!p_rst_n) begin
            model_reset();
        end else if (m_owner == 0) begin
            m_ack = 1'b0;
            m_cnt = 0;
            if (p_req[0] && (!p_req[1] || m_last == 1)) m_owner = 1;
            else if (p_req[1])                         m_owner = 2;
        end else begin
            n = m_owner - 1;
            if (!m_ack) begin
                if (p_req[n]) begin
                    exp_regs[p_sel[n]] = p_data[n];
                    m_cnt++;
                    m_ack = 1'b1;
                end else begin
                    m_last  = n;
                    m_owner = 0;
                end
            end else begin
                m_ack = 1'b0;
                if (!(p_lock[n] && m_cnt < MAX_BURST)) begin
                    m_last  = n;
                    m_owner = 0;
                end
            end
        end
        chk("owner",     32'(bus.owner),     32'(m_owner));
        chk("r0_ack",    32'(bus.r0_ack),    32'(m_ack && m_owner == 1));
        chk("r1_ack",    32'(bus.r1_ack),    32'(m_ack && m_owner == 2));
        chk("ack_excl",  32'(bus.r0_ack & bus.r1_ack), 32'd0);
        chk("hexl",      bus.hexl_out,       exp_regs[0]);
        chk("hexr",      bus.hexr_out,       exp_regs[1]);
        chk("ledsred",   bus.ledsred_out,    exp_regs[2]);
        chk("ledsgreen", bus.ledsgreen_out,  exp_regs[3]);
        if (bus.r0_ack === 1'b1) begin
            ack_log.push_back(0);
            ack_cnt0++;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (bus.r1_ack === 1'b1) begin
            ack_log.push_back(1);
            ack_cnt1++;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        drive();
    endtask

    task automatic do_reset(input int cycles);
        q0.delete();
        q1.delete();
        burst0 = 1'b0;
        burst1 = 1'b0;
        mask0  = 1'b0;
        reset_reset_n = 1'b0;
        drive();
        repeat (cycles) step();
        reset_reset_n = 1'b1;
    endtask

    // Run until both requesters are empty, bounded by a cycle budget.
    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(q0.size() + q1.size()), 32'd0);
        repeat (3) step();
    endtask

    task automatic check_ack_order(input string tag);
        chk({tag, "_len"}, 32'(ack_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++)
            chk(tag, 32'(ack_log[i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int pushed0;
        int pushed1;
        beat_t b;
        drive();

        // Reset held for three cycles.
        do_reset(3);
        chk("rst_hexl",  bus.hexl_out,      32'hFFFF_FFFF);
        chk("rst_green", bus.ledsgreen_out, 32'h0000_0000);

        // Single uncontended write to ledsred.
        q0.push_back('{sel: 2'd2, data: 32'h0000_00A5});
        drive();
        step();
        chk("single_own",   32'(bus.owner),     32'h1);
        chk("single_noack", 32'(bus.r0_ack),    32'h0);
        step();
        chk("single_ack",   32'(bus.r0_ack),    32'h1);
        chk("single_red",   bus.ledsred_out,    32'h0000_00A5);
        step();
        chk("single_ack_off", 32'(bus.r0_ack),  32'h0);
        chk("single_release", 32'(bus.owner),   32'h0);

        // Rewriting the same value still produces an ack.
        q0.push_back('{sel: 2'd2, data: 32'h0000_00A5});
        drive();
        step();
        step();
        chk("same_val_ack", 32'(bus.r0_ack), 32'h1);
        chk("same_val_red", bus.ledsred_out, 32'h0000_00A5);
        step();

        // Contention straight out of reset: r0 first, then r1.
        do_reset(2);
        q0.push_back('{sel: 2'd0, data: 32'h0000_0001});
        q1.push_back('{sel: 2'd1, data: 32'h0000_0002});
        ack_log.delete();
        drive();
        drain("contend_drain", 50);
        chk("contend_hexl", bus.hexl_out, 32'h0000_0001);
        chk("contend_hexr", bus.hexr_out, 32'h0000_0002);
        exp_q = '{1'b0, 1'b1};
        check_ack_order("contend_order");

        // Burst limit: locked r1 with six beats is cut after MAX_BURST.
        do_reset(2);
        burst1 = 1'b1;
        for (int i = 0; i < 6; i++)
            q1.push_back('{sel: 2'($urandom_range(0, 3)), data: $urandom});
        drive();
        step();
        chk("burst_r1_first", 32'(bus.owner), 32'h2);
        q0.push_back('{sel: 2'd3, data: $urandom});
        ack_log.delete();
        drive();
        drain("burst_drain", 100);
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        check_ack_order("burst_order");
        burst1 = 1'b0;

        // Reset during OWN0 aborts the write and the ack.
        do_reset(2);
        q0.push_back('{sel: 2'd3, data: 32'h0000_00FF});
        drive();
        step();
        chk("abort_own", 32'(bus.owner), 32'h1);
        reset_reset_n = 1'b0;
        step();
        chk("abort_green", bus.ledsgreen_out, 32'h0);
        chk("abort_ack",   32'(bus.r0_ack),   32'h0);
        q0.delete();
        reset_reset_n = 1'b1;
        drive();
        step();
        chk("abort_no_late_ack", 32'(bus.r0_ack),   32'h0);
        chk("abort_green_hold",  bus.ledsgreen_out, 32'h0);

        // r0 drops its request while in OWN0. Pending r1 is granted next.
        do_reset(2);
        q0.push_back('{sel: 2'd0, data: 32'h0000_1234});
        q1.push_back('{sel: 2'd1, data: 32'h0000_5678});
        drive();
        step();
        chk("drop_own0", 32'(bus.owner), 32'h1);
        mask0 = 1'b1;
        drive();
        step();
        chk("drop_owner_none", 32'(bus.owner),   32'h0);
        chk("drop_no_ack",     32'(bus.r0_ack),  32'h0);
        chk("drop_no_write",   bus.hexl_out,     HEX_BLANK);
        step();
        chk("drop_r1_granted", 32'(bus.owner),   32'h2);
        q0.delete();
        mask0 = 1'b0;
        drive();
        drain("drop_drain", 20);
        chk("drop_hexr", bus.hexr_out, 32'h0000_5678);

        // Random traffic on both requesters, bursts switched at random.
        do_reset(2);
        ack_cnt0 = 0;
        ack_cnt1 = 0;
        pushed0  = 0;
        pushed1  = 0;
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0) burst0 = 1'($urandom_range(0, 1));
            if (q1.size() == 0) burst1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && q0.size() < 6) begin
                b.sel  = 2'($urandom_range(0, 3));
                b.data = $urandom;
                q0.push_back(b);
                pushed0++;
            end
            if ($urandom_range(0, 3) == 0 && q1.size() < 6) begin
                b.sel  = 2'($urandom_range(0, 3));
                b.data = $urandom;
                q1.push_back(b);
                pushed1++;
            end
            drive();
            step();
        end
        drain("rand_drain", 300);
        chk("rand_acks0", 32'(ack_cnt0), 32'(pushed0));
        chk("rand_acks1", 32'(ack_cnt1), 32'(pushed1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
